// File: rtl/reverse_dabbler_pkg.sv
// Shared definitions for the reverse double-dabble BCD-to-binary converter.
// State encodings, digit/iteration counts and an operand validity helper.
package reverse_dabbler_pkg;

    localparam int NDIGITS = 3;
    localparam int NSHIFT  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic has_bad_digit(input logic [4*NDIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/reverse_dabbler_nibble_sub3.sv
// Per-digit correction step: a shifted BCD digit of 8 or more had a tens
// carry folded into it, so pulling 3 back out restores a valid digit.
module nibble_sub3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/reverse_dabbler.sv
// Sequential 3-digit BCD to binary converter (reverse double dabble).
// One right shift per cycle; the result registers update on the last shift.
//
//   state | meaning
//   IDLE  | waiting for start; operand captured on the start edge
//   SHIFT | one shift + digit correction per cycle, NSHIFT cycles
//   DONE  | one-cycle done pulse, result outputs valid
module reverse_dabbler #(
    parameter int NSHIFT = reverse_dabbler_pkg::NSHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [7:0]  bin,
    output logic        ovf,
    output logic        err
);
    import reverse_dabbler_pkg::*;

    localparam int CW = (NSHIFT > 1) ? $clog2(NSHIFT) : 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [11:0]         work_q, work_d;
    logic [NSHIFT-1:0]   acc_q, acc_d;
    logic                operr_q, operr_d;
    logic [7:0]          bin_q, bin_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic [11:0]         work_sh;
    logic [11:0]         work_fix;
    logic [NSHIFT-1:0]   acc_sh;

    assign work_sh = {1'b0, work_q[11:1]};
    assign acc_sh  = {work_q[0], acc_q[NSHIFT-1:1]};

    // Correction happens on the already-shifted digits.
    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        nibble_sub3 u_sub3 (
            .nib_i (work_sh[4*g +: 4]),
            .nib_o (work_fix[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            acc_q   <= '0;
            operr_q <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            operr_q <= operr_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        acc_d   = acc_q;
        operr_d = operr_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    operr_d = has_bad_digit(bcd);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = work_fix;
                acc_d  = acc_sh;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(NSHIFT - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    // Invalid operands report a clean zero result.
                    bin_d   = operr_q ? 8'h00 : acc_sh[7:0];
                    ovf_d   = operr_q ? 1'b0 : |acc_sh[NSHIFT-1:8];
                    err_d   = operr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bin  = bin_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

endmodule

// File: tb/tb_reverse_dabbler.sv
// Directed bench for reverse_dabbler: hand-computed conversions, latency,
// start masking, continuous start throughput and mid-conversion reset.
module tb_reverse_dabbler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [7:0]  bin;
    logic        ovf;
    logic        err;

    int n_checks;
    int n_fail;

    reverse_dabbler dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .ovf   (ovf),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a conversion, waits (bounded) for done and checks latency and results.
    task automatic run_conv(input string tag, input logic [11:0] v,
                            input logic [7:0] exp_bin, input logic exp_ovf, input logic exp_err);
        int n;
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bcd   = 12'h000;
        check_eq({tag, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " latency"}, 32'(n), 32'd10);
        check_eq({tag, " bin"}, 32'(bin), 32'(exp_bin));
        check_eq({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        check_eq({tag, " err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check_eq({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int ndone;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b1;
        bcd   = 12'h243;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset bin",  32'(bin),  32'd0);
        check_eq("reset ovf",  32'(ovf),  32'd0);
        check_eq("reset err",  32'(err),  32'd0);
        rst   = 1'b0;
        start = 1'b0;

        run_conv("c243", 12'h243, 8'hF3, 1'b0, 1'b0);
        run_conv("c000", 12'h000, 8'h00, 1'b0, 1'b0);
        run_conv("c255", 12'h255, 8'hFF, 1'b0, 1'b0);
        run_conv("c999", 12'h999, 8'hE7, 1'b1, 1'b0);
        run_conv("c1A5", 12'h1A5, 8'h00, 1'b0, 1'b1);
        run_conv("c256", 12'h256, 8'h00, 1'b1, 1'b0);
        run_conv("c100", 12'h100, 8'h64, 1'b0, 1'b0);
        run_conv("c511", 12'h511, 8'hFF, 1'b1, 1'b0);
        run_conv("c9F0", 12'h9F0, 8'h00, 1'b0, 1'b1);
        run_conv("c087", 12'h087, 8'h57, 1'b0, 1'b0);

        // Results hold while idle.
        repeat (5) @(negedge clk);
        check_eq("hold bin", 32'(bin), 32'h57);
        check_eq("hold busy", 32'(busy), 32'd0);

        // Start and operand changes during SHIFT must be ignored.
        @(negedge clk);
        bcd   = 12'h128;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bcd   = 12'h077;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("mask done seen", 32'(done), 32'd1);
        check_eq("mask bin", 32'(bin), 32'h80);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("mask no second done", 32'(ndone), 32'd0);

        // Continuous start: back-to-back conversions every 12 cycles.
        @(negedge clk);
        bcd   = 12'h050;
        start = 1'b1;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("cont first done", 32'(done), 32'd1);
        check_eq("cont bin", 32'(bin), 32'h32);
        @(negedge clk);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("cont interval", 32'(n), 32'd12);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("cont stop busy", 32'(busy), 32'd0);

        // Reset mid-conversion aborts with no done and clears outputs.
        run_conv("pre999", 12'h999, 8'hE7, 1'b1, 1'b0);
        @(negedge clk);
        bcd   = 12'h243;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort bin",  32'(bin),  32'd0);
        check_eq("abort ovf",  32'(ovf),  32'd0);
        check_eq("abort err",  32'(err),  32'd0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("abort no done", 32'(ndone), 32'd0);
        run_conv("c064", 12'h064, 8'h40, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
